programmable_modulus_counter: RTL and testbench
===============================================

PROGRAMMABLE_MODULUS_COUNTER -- requirements
Module: programmable_modulus_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits (WIDTH >= 2).
REQ-002 The block SHALL have parameter WRAP_W, default 8, giving the wrap-counter width in bits (WRAP_W >= 1).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL have port en, input, 1, the count enable; one step per clk cycle while high.
REQ-006 The block SHALL have port up_dn, input, 1, the direction: 1 = count up, 0 = count down.
REQ-007 The block SHALL have port mod_val, input, WIDTH, the runtime modulus M; the count sequence is 0..M-1.
REQ-008 The block SHALL have port Q, output, WIDTH, the registered count value.
REQ-009 The block SHALL have port tc, output, 1, the combinational terminal-count flag.
REQ-010 The block SHALL have port wrap_cnt, output, WRAP_W, the registered saturating count of wrap events.
REQ-011 When MODCNT_LOAD_EN is defined, the block SHALL also have port load, input, 1, a synchronous parallel-load strobe, and port load_val, input, WIDTH, the load data.

Function
REQ-012 The block SHALL define the effective modulus Me = 1 when mod_val < 2, else Me = mod_val; all comparisons use Me, and arithmetic is unsigned and WIDTH bits.
REQ-013 When en=1 and up_dn=1, the block SHALL set next Q = 0 if Q >= Me-1, else Q+1.
REQ-014 When en=1 and up_dn=0, the block SHALL set next Q = Me-1 if Q == 0 or Q > Me-1, else Q-1.
REQ-015 When en=0, the block SHALL hold Q, and tc SHALL be 0.
REQ-016 The block SHALL drive tc = en AND (up_dn ? Q >= Me-1 : (Q == 0 OR Q > Me-1)); tc is high exactly in the cycle whose enabled step wraps.
REQ-017 In each cycle with tc=1, the block SHALL increment wrap_cnt by 1, saturating at 2^WRAP_W-1.
REQ-018 When Me = 1, the block SHALL hold Q at 0 and assert tc in every enabled cycle.
REQ-019 A mod_val change SHALL take effect on the next edge with no latency; an out-of-range Q is corrected only by the next enabled step, per REQ-013/014.
REQ-020 A direction change SHALL take effect on the same edge; no idle cycle is inserted.

Reset
REQ-021 When reset=1 at a rising clk edge, the block SHALL set Q = 0 and wrap_cnt = 0, overriding load and en.
REQ-022 During reset, tc SHALL follow REQ-016 from the current Q; wrap_cnt SHALL not increment in a reset cycle.
REQ-023 A reset asserted mid-sequence SHALL take effect on that edge; counting SHALL resume from 0 in the first cycle after reset deasserts.

Configuration
REQ-024 With macro MODCNT_LOAD_EN defined, load=1 SHALL set next Q = load_val, or Me-1 if load_val > Me-1; load takes priority over en, forces tc to 0, and leaves wrap_cnt unchanged.
REQ-025 Without MODCNT_LOAD_EN, the load and load_val ports SHALL be absent and Q SHALL change only through reset and the enabled steps.

Verification
REQ-026 The bench SHALL check: reset, mod_val=12, up_dn=1, en=1 for 24 cycles -> Q goes 0..11,0..11; tc high at Q=11 twice; wrap_cnt=2.
REQ-027 The bench SHALL check: mod_val=5, up_dn=0 from reset -> Q goes 4,3,2,1,0,4; tc high whenever Q=0.
REQ-028 The bench SHALL check: mod_val=10 with Q=8, then mod_val changed to 6 -> the next enabled up step gives Q=0 with tc=1; the next down step from Q=8 gives Q=5.
REQ-029 The bench SHALL check: mod_val=0 and then mod_val=1, with en=1 -> Q stays 0, tc=1 every cycle, wrap_cnt saturates at 255 (WRAP_W=8).
REQ-030 The bench SHALL check: with MODCNT_LOAD_EN, mod_val=12, load=1 with load_val=7 -> Q=7; with load_val=15 -> Q=11; load=1 together with en=1 -> load wins and tc=0.
REQ-031 The bench SHALL check: reset=1 with en=1 and load=1 at Q=9 -> Q=0 and wrap_cnt=0 on that edge; Q=1 on the next edge after reset deasserts.

Source files
------------

// File: rtl/programmable_modulus_counter.sv
// Programmable-modulus up/down counter with a saturating wrap-event counter.
// Define MODCNT_LOAD_EN to add the synchronous parallel-load port pair (load, load_val).
module programmable_modulus_counter #(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              up_dn,
    input  logic [WIDTH-1:0]  mod_val,
`ifdef MODCNT_LOAD_EN
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
`endif
    output logic [WIDTH-1:0]  Q,
    output logic              tc,
    output logic [WRAP_W-1:0] wrap_cnt
);

    logic [WIDTH-1:0]  me_s;
    logic [WIDTH-1:0]  top_s;
    logic              wrap_evt_s;
    logic              tc_s;
    logic              load_s;
    logic [WIDTH-1:0]  load_val_s;
    logic [WIDTH-1:0]  q_d;
    logic [WIDTH-1:0]  q_q;
    logic [WRAP_W-1:0] wrap_d;
    logic [WRAP_W-1:0] wrap_q;

`ifdef MODCNT_LOAD_EN
    assign load_s     = load;
    assign load_val_s = load_val;
`else
    assign load_s     = 1'b0;
    assign load_val_s = {WIDTH{1'b0}};
`endif

    // Effective modulus: degenerate moduli (0, 1) behave as a modulus of 1.
    always_comb begin
        me_s = mod_val;
        if (mod_val < WIDTH'(2)) begin
            me_s = WIDTH'(1);
        end else begin
            me_s = mod_val;
        end
        top_s = me_s - WIDTH'(1);
    end

    // Wrap detection; an out-of-range Q counts as a wrap in either direction.
    always_comb begin
        wrap_evt_s = 1'b0;
        if (up_dn) begin
            wrap_evt_s = (q_q >= top_s);
        end else begin
            wrap_evt_s = (q_q == {WIDTH{1'b0}}) || (q_q > top_s);
        end
        tc_s = en & ~load_s & wrap_evt_s;
    end

    // Next count value: load, then enabled step, else hold.
    always_comb begin
        q_d = q_q;
        if (load_s) begin
            if (load_val_s > top_s) begin
                q_d = top_s;
            end else begin
                q_d = load_val_s;
            end
        end else if (en) begin
            if (up_dn) begin
                q_d = wrap_evt_s ? {WIDTH{1'b0}} : (q_q + WIDTH'(1));
            end else begin
                q_d = wrap_evt_s ? top_s : (q_q - WIDTH'(1));
            end
        end else begin
            q_d = q_q;
        end
    end

    // Saturating wrap-event counter.
    always_comb begin
        wrap_d = wrap_q;
        if (tc_s && (wrap_q != {WRAP_W{1'b1}})) begin
            wrap_d = wrap_q + WRAP_W'(1);
        end else begin
            wrap_d = wrap_q;
        end
    end

    // State registers with synchronous reset overriding load and enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q    <= {WIDTH{1'b0}};
            wrap_q <= {WRAP_W{1'b0}};
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign Q        = q_q;
    assign tc       = tc_s;
    assign wrap_cnt = wrap_q;

endmodule

// File: tb/tb_programmable_modulus_counter.sv
// Self-checking bench: directed scenarios plus randomized traffic against an arithmetic reference model.
module tb_programmable_modulus_counter;

    localparam int WIDTH  = 4;
    localparam int WRAP_W = 8;
    localparam int WMAX   = (1 << WRAP_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic              up_dn;
    logic [WIDTH-1:0]  mod_val;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic [WIDTH-1:0]  Q;
    logic              tc;
    logic [WRAP_W-1:0] wrap_cnt;

    int checks = 0;
    int errors = 0;
    int m_q    = 0;
    int m_wrap = 0;
    int tc_hits = 0;

    always #5 clk = ~clk;

    programmable_modulus_counter #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up_dn    (up_dn),
        .mod_val  (mod_val),
`ifdef MODCNT_LOAD_EN
        .load     (load),
        .load_val (load_val),
`endif
        .Q        (Q),
        .tc       (tc),
        .wrap_cnt (wrap_cnt)
    );

    function automatic int eff_mod(input int m);
        return (m < 2) ? 1 : m;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check tc against the model, clock, check state.
    task automatic step(input logic r, input logic e, input logic u, input int m,
                        input logic ld = 1'b0, input int lv = 0);
        int  me;
        bit  exp_tc;
        bit  wraps;
        bit  ld_eff;
`ifdef MODCNT_LOAD_EN
        ld_eff = ld;
`else
        ld_eff = 1'b0;
`endif
        reset = r; en = e; up_dn = u; mod_val = WIDTH'(m); load = ld; load_val = WIDTH'(lv);
        me = eff_mod(m);
        wraps  = u ? (m_q >= me - 1) : (m_q == 0 || m_q > me - 1);
        exp_tc = e && !ld_eff && wraps;
        #1;
        check("tc", int'(tc), int'(exp_tc));
        if (tc === 1'b1) tc_hits++;
        @(posedge clk);
        if (r) begin
            m_q = 0; m_wrap = 0;
        end else begin
            if (ld_eff)  m_q = (lv > me - 1) ? me - 1 : lv;
            else if (e)  m_q = u ? (wraps ? 0 : m_q + 1) : (wraps ? me - 1 : m_q - 1);
            if (exp_tc && m_wrap < WMAX) m_wrap++;
        end
        #1;
        check("Q", int'(Q), m_q);
        check("wrap_cnt", int'(wrap_cnt), m_wrap);
    endtask

    initial begin
        int seq5 [6] = '{4, 3, 2, 1, 0, 4};
        reset = 1'b1; en = 1'b0; up_dn = 1'b1; mod_val = '0; load = 1'b0; load_val = '0;
        @(posedge clk); #1;

        // Reset state
        step(1'b1, 1'b0, 1'b1, 12);
        check("reset_Q", int'(Q), 0);
        check("reset_wrap", int'(wrap_cnt), 0);

        // Modulus 12 up for two full periods
        tc_hits = 0;
        for (int i = 0; i < 24; i++) begin
            step(1'b0, 1'b1, 1'b1, 12);
            check("up12_seq", int'(Q), (i + 1) % 12);
        end
        check("up12_tc_hits", tc_hits, 2);
        check("up12_wrap", int'(wrap_cnt), 2);

        // Modulus 5 down from reset
        step(1'b1, 1'b0, 1'b0, 5);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'b0, 5);
            check("dn5_seq", int'(Q), seq5[i]);
        end

        // Shrinking modulus with Q out of range, up step
        step(1'b1, 1'b0, 1'b1, 10);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 10);
        check("pre_shrink_Q", int'(Q), 8);
        mod_val = WIDTH'(6); up_dn = 1'b1; en = 1'b1; #1;
        check("shrink_up_tc", int'(tc), 1);
        step(1'b0, 1'b1, 1'b1, 6);
        check("shrink_up_Q", int'(Q), 0);

        // Shrinking modulus with Q out of range, down step
        step(1'b1, 1'b0, 1'b1, 10);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 10);
        step(1'b0, 1'b1, 1'b0, 6);
        check("shrink_dn_Q", int'(Q), 5);

        // Degenerate moduli 0 and 1: Q stuck at 0, wrap counter saturates
        step(1'b1, 1'b0, 1'b1, 0);
        for (int i = 0; i < 130; i++) step(1'b0, 1'b1, 1'b1, 0);
        for (int i = 0; i < 130; i++) step(1'b0, 1'b1, i[0], 1);
        check("deg_Q", int'(Q), 0);
        check("deg_wrap_sat", int'(wrap_cnt), 255);

`ifdef MODCNT_LOAD_EN
        // Parallel load with clamping and priority over enable
        step(1'b1, 1'b0, 1'b1, 12);
        step(1'b0, 1'b0, 1'b1, 12, 1'b1, 7);
        check("load7", int'(Q), 7);
        step(1'b0, 1'b0, 1'b1, 12, 1'b1, 15);
        check("load15_clamp", int'(Q), 11);
        step(1'b0, 1'b1, 1'b1, 12, 1'b1, 3);
        check("load_vs_en", int'(Q), 3);
`endif

        // Mid-sequence reset at Q=9
        step(1'b1, 1'b0, 1'b1, 12);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b1, 12);
        check("pre_reset_Q", int'(Q), 9);
        step(1'b1, 1'b1, 1'b1, 12, 1'b1, 5);
        check("mid_reset_Q", int'(Q), 0);
        check("mid_reset_wrap", int'(wrap_cnt), 0);
        step(1'b0, 1'b1, 1'b1, 12);
        check("post_reset_Q", int'(Q), 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
                 int'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0),
                 int'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
